// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN transmit-side types and constants
package can_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLAG  = 2'd1,
        WAIT  = 2'd2,
        DELIM = 2'd3
    } txState_e;

    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    // Flag/delimiter lengths are common to overload and error frames
    localparam int FLAG_LEN  = 6;
    localparam int DELIM_LEN = 8;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - saturating bit-time counter with clear, load-1 and enable
module bit_counter
    import can_pkg::*;
(
    input  logic             clock,
    input  logic             resetN,
    input  logic             samplePoint,
    input  logic             clear,
    input  logic             load1,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (samplePoint) begin
            if (clear) begin
                count <= '0;
            end else if (load1) begin
                count <= CNT_W'(1);
            end else if (enable && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/overload_frame_tx.sv
// rtl/overload_frame_tx.sv - CAN overload frame transmitter (flag, superposition wait, delimiter)
// Optional OVF_LIMIT_EN: caps self-initiated overload frames at two per received frame.
module overload_frame_tx
    import can_pkg::*;
#(
    parameter int FLAG_BITS    = FLAG_LEN,
    parameter int DELIM_BITS   = DELIM_LEN,
    parameter int MAX_SUPERPOS = 7
) (
    input  logic clock,
    input  logic resetN,
    input  logic samplePoint,
    input  logic canRX,
    input  logic frameReady,
    input  logic isOverload,
    input  logic overloadReq,
    output logic canTX,
    output logic endOverload,
    output logic busy,
    output logic formError,
    output logic stuckError
);

    localparam logic [CNT_W-1:0] FLAG_LAST    = CNT_W'(FLAG_BITS - 1);
    localparam logic [CNT_W-1:0] DELIM_LAST   = CNT_W'(DELIM_BITS - 1);
    localparam logic [CNT_W-1:0] SUPERPOS_MAX = CNT_W'(MAX_SUPERPOS);

    txState_e         state;
    logic [CNT_W-1:0] cnt;
    logic             cntClear;
    logic             cntLoad1;
    logic             cntEnable;
    logic             reqLimited;
    logic             request;

`ifdef OVF_LIMIT_EN
    logic [1:0] ovfCount;

    assign reqLimited = (ovfCount == 2'd2);

    // Only frames started by overloadReq alone count against the limit
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ovfCount <= 2'd0;
        end else if (samplePoint) begin
            if (!frameReady) begin
                ovfCount <= 2'd0;
            end else if ((state == IDLE) && overloadReq && !isOverload && !reqLimited) begin
                ovfCount <= ovfCount + 2'd1;
            end
        end
    end
`else
    logic unusedFrameReady;

    assign unusedFrameReady = frameReady;
    assign reqLimited       = 1'b0;
`endif

    assign request = isOverload | (overloadReq & ~reqLimited);
    assign busy    = (state != IDLE);

    // Holding the counter clear throughout IDLE gives cnt = 0 on entry to FLAG
    always_comb begin
        cntClear  = 1'b0;
        cntLoad1  = 1'b0;
        cntEnable = 1'b0;
        case (state)
            IDLE: cntClear = 1'b1;
            FLAG: begin
                if (cnt == FLAG_LAST) cntClear  = 1'b1;
                else                  cntEnable = 1'b1;
            end
            WAIT: begin
                if (canRX == RECESSIVE)       cntLoad1  = 1'b1;
                else if (cnt == SUPERPOS_MAX) cntClear  = 1'b1;
                else                          cntEnable = 1'b1;
            end
            DELIM: begin
                if ((canRX == RECESSIVE) && (cnt != DELIM_LAST)) cntEnable = 1'b1;
                else                                             cntClear  = 1'b1;
            end
            default: cntClear = 1'b1;
        endcase
    end

    bit_counter u_bitCounter (
        .clock       (clock),
        .resetN      (resetN),
        .samplePoint (samplePoint),
        .clear       (cntClear),
        .load1       (cntLoad1),
        .enable      (cntEnable),
        .count       (cnt)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            canTX       <= RECESSIVE;
            endOverload <= 1'b0;
            formError   <= 1'b0;
            stuckError  <= 1'b0;
        end else if (samplePoint) begin
            endOverload <= 1'b0;
            formError   <= 1'b0;
            stuckError  <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        canTX <= DOMINANT;
                        state <= FLAG;
                    end
                end
                FLAG: begin
                    if (cnt == FLAG_LAST) begin
                        canTX <= RECESSIVE;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (canRX == RECESSIVE) begin
                        state <= DELIM;
                    end else if (cnt == SUPERPOS_MAX) begin
                        stuckError <= 1'b1;
                        state      <= IDLE;
                    end
                end
                DELIM: begin
                    if (canRX == DOMINANT) begin
                        formError <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt == DELIM_LAST) begin
                        endOverload <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    canTX <= RECESSIVE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
